// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_GRANT = 3'b010,
        ST_IFG   = 3'b100
    } state_e;

    localparam int GNT_ARP        = 0;
    localparam int GNT_UDP        = 1;
    localparam int IFG_CYCLES_DEF = 12;
    localparam int WDOG_CNT_W     = 12;

endpackage

// File: rtl/gmii_rr_arbiter.sv
// Two-way ARP/UDP grant decision; last_grant advances when a frame ends.
module gmii_rr_arbiter
    import gmii_tx_pkg::*;
#(
    parameter int ARP_PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_arp,
    input  logic       req_udp,
    input  logic       done_stb,
    input  logic [1:0] done_gnt,
    output logic [1:0] gnt
);

    // 1 = UDP was served last, so ARP wins the first tie
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (done_stb) last_grant_d = done_gnt[GNT_UDP];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= 1'b1;
        else     last_grant_q <= last_grant_d;
    end

    always_comb begin
        gnt = '0;
        if (req_arp && req_udp) begin
            if (ARP_PRIORITY != 0 || last_grant_q) gnt[GNT_ARP] = 1'b1;
            else                                   gnt[GNT_UDP] = 1'b1;
        end else if (req_arp) begin
            gnt[GNT_ARP] = 1'b1;
        end else if (req_udp) begin
            gnt[GNT_UDP] = 1'b1;
        end
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Grants the GMII transmitter and shared CRC32 engine to ARP or UDP, then enforces IFG.
// Optional grant watchdog: define GMII_TX_ARB_WDOG_EN.
module gmii_tx_arbiter
    import gmii_tx_pkg::*;
#(
    parameter int IFG_CYCLES   = IFG_CYCLES_DEF,
    parameter int ARP_PRIORITY = 1,
    parameter int WDOG_CYCLES  = 2048
) (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic       arp_tx_req,
    output logic       arp_tx_sel,
    input  logic       arp_tx_done,
    input  logic       arp_gmii_tx_en,
    input  logic [7:0] arp_gmii_txd,
    input  logic       arp_crc_en,
    input  logic       arp_crc_clr,
    input  logic       udp_tx_req,
    output logic       udp_tx_sel,
    input  logic       udp_tx_done,
    input  logic       udp_gmii_tx_en,
    input  logic [7:0] udp_gmii_txd,
    input  logic       udp_crc_en,
    input  logic       udp_crc_clr,
    output logic       crc_en,
    output logic       crc_clr,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
`ifdef GMII_TX_ARB_WDOG_EN
    output logic       wdog_abort,
`endif
    output logic       tx_busy
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    if (IFG_CYCLES < 1 || WDOG_CYCLES < 1 || WDOG_CYCLES > (1 << WDOG_CNT_W)) begin : g_bad_cfg
        $error("gmii_tx_arbiter: IFG_CYCLES or WDOG_CYCLES out of range");
    end

    state_e             state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [IFG_W-1:0]   ifg_cnt_q, ifg_cnt_d;
    logic               gmii_tx_en_q, gmii_tx_en_d;
    logic [7:0]         gmii_txd_q, gmii_txd_d;
    logic [1:0]         arb_gnt;
    logic               granted, done_hit, wdog_hit, frame_end, wdog_pulse;
    logic               mux_en, mux_crc_en, mux_crc_clr;
    logic [7:0]         mux_txd;

    assign granted     = (state_q == ST_GRANT);
    assign mux_en      = gnt_q[GNT_ARP] ? arp_gmii_tx_en : udp_gmii_tx_en;
    assign mux_txd     = gnt_q[GNT_ARP] ? arp_gmii_txd   : udp_gmii_txd;
    assign mux_crc_en  = gnt_q[GNT_ARP] ? arp_crc_en     : udp_crc_en;
    assign mux_crc_clr = gnt_q[GNT_ARP] ? arp_crc_clr    : udp_crc_clr;
    assign done_hit    = granted && ((gnt_q[GNT_ARP] && arp_tx_done) ||
                                     (gnt_q[GNT_UDP] && udp_tx_done));
    assign frame_end   = done_hit || wdog_hit;

`ifdef GMII_TX_ARB_WDOG_EN
    logic [WDOG_CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic                  wdog_abort_q, wdog_abort_d;

    assign wdog_hit = granted && !done_hit &&
                      (wdog_cnt_q == WDOG_CNT_W'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_cnt_d   = granted ? wdog_cnt_q + 1'b1 : '0;
        wdog_abort_d = wdog_hit;
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q   <= '0;
            wdog_abort_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_abort_q <= wdog_abort_d;
        end
    end

    assign wdog_pulse = wdog_abort_q;
    assign wdog_abort = wdog_abort_q;
`else
    assign wdog_hit   = 1'b0;
    assign wdog_pulse = 1'b0;
`endif

    gmii_rr_arbiter #(
        .ARP_PRIORITY (ARP_PRIORITY)
    ) u_arb (
        .clk      (gmii_tx_clk),
        .rst      (rst),
        .req_arp  (arp_tx_req),
        .req_udp  (udp_tx_req),
        .done_stb (frame_end),
        .done_gnt (gnt_q),
        .gnt      (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ifg_cnt_d = ifg_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (frame_end) begin
                    gnt_d     = '0;
                    ifg_cnt_d = IFG_W'(IFG_CYCLES - 1);
                    state_d   = ST_IFG;
                end
            end
            ST_IFG: begin
                if (ifg_cnt_q == '0) state_d = ST_IDLE;
                else                 ifg_cnt_d = ifg_cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // a watchdog abort also suppresses the byte presented in the abort cycle
    always_comb begin
        gmii_tx_en_d = granted && !wdog_hit && mux_en;
        gmii_txd_d   = (granted && !wdog_hit) ? mux_txd : 8'h00;
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            ifg_cnt_q    <= '0;
            gmii_tx_en_q <= 1'b0;
            gmii_txd_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ifg_cnt_q    <= ifg_cnt_d;
            gmii_tx_en_q <= gmii_tx_en_d;
            gmii_txd_q   <= gmii_txd_d;
        end
    end

    assign arp_tx_sel = granted && gnt_q[GNT_ARP];
    assign udp_tx_sel = granted && gnt_q[GNT_UDP];
    assign crc_en     = granted && mux_crc_en;
    assign crc_clr    = (granted && mux_crc_clr) || wdog_pulse;
    assign gmii_tx_en = gmii_tx_en_q;
    assign gmii_txd   = gmii_txd_q;
    assign tx_busy    = (state_q != ST_IDLE);

endmodule
